// File: rtl/slave_daq_pkg.sv
// -----------------------------------------------------------------------------
// slave_daq_pkg
// Shared definitions for the HARDROC acquisition sequencer:
//   - default timing/width parameters
//   - sequencer state encoding
//   - power-pulsing masks, bit order {A, D, ADC, DAC} (A is the MSB)
// Optional feature macro: SLAVE_DAQ_TRIG_TIMEOUT_EN adds the ABORT state.
// -----------------------------------------------------------------------------
package slave_daq_pkg;

   localparam int DEF_PWR_SETTLE_CYCLES = 1000;  // 25 us at 40 MHz
   localparam int DEF_RESET_LOW_CYCLES  = 4;
   localparam int DEF_CNT_W             = 16;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_PWR_UP     = 3'd1,
      ST_RESET_CHIP = 3'd2,
      ST_ACQ        = 3'd3,
      ST_READOUT    = 3'd4
`ifdef SLAVE_DAQ_TRIG_TIMEOUT_EN
      , ST_ABORT    = 3'd5
`endif
   } daqState_t;

   // Power masks, {A, D, ADC, DAC}
   localparam logic [3:0] PWR_MASK_OFF     = 4'b0000;
   localparam logic [3:0] PWR_MASK_ON      = 4'b1111;
   localparam logic [3:0] PWR_MASK_READOUT = 4'b0101;  // analog and ADC off, digital and DAC kept up

   // Power mask driven while the sequencer sits in a given state
   function automatic logic [3:0] pwrMaskFor(input daqState_t st);
      logic [3:0] mask;
      case (st)
         ST_IDLE:       mask = PWR_MASK_OFF;
         ST_PWR_UP:     mask = PWR_MASK_ON;
         ST_RESET_CHIP: mask = PWR_MASK_ON;
         ST_ACQ:        mask = PWR_MASK_ON;
         ST_READOUT:    mask = PWR_MASK_READOUT;
`ifdef SLAVE_DAQ_TRIG_TIMEOUT_EN
         ST_ABORT:      mask = PWR_MASK_ON;
`endif
         default:       mask = PWR_MASK_OFF;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/slave_daq_ctrl_trig_sync_edge.sv
// -----------------------------------------------------------------------------
// trig_sync_edge
// 2-FF synchroniser followed by a rising-edge detector. The detector compares
// the synchronised level against its own registered copy, so riseOut is high
// for exactly one cycle per synchronised rising edge.
// Ports:
//   clk      in   clock of the destination domain
//   reset    in   synchronous, active-high
//   asyncIn  in   asynchronous input
//   syncOut  out  synchronised level
//   riseOut  out  one-cycle pulse on a synchronised rising edge
// -----------------------------------------------------------------------------
module trig_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic asyncIn,
   output logic syncOut,
   output logic riseOut
);

   // [0] metastability stage, [1] synchronised level, [2] delayed level
   logic [2:0] shift_r;

   // Synchroniser chain and edge-detector history register
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_r <= 3'b000;
      end else begin
         shift_r <= {shift_r[1:0], asyncIn};
      end
   end

   assign syncOut = shift_r[1];
   assign riseOut = shift_r[1] & ~shift_r[2];

endmodule

// File: rtl/slave_daq_ctrl.sv
// -----------------------------------------------------------------------------
// slave_daq_ctrl
// Externally triggered acquisition sequencer for HARDROC front-end chips:
// power up, settle, chip reset, acquire until trigger or memory full, read out,
// repeat while SlaveAcq_Start stays high.
// Optional feature macro: SLAVE_DAQ_TRIG_TIMEOUT_EN (acquisition window limit
// via AcqTimeout and an ABORT state; otherwise AcqTimeout is ignored).
// Ports:
//   Clk, reset               clock, synchronous active-high reset
//   SlaveAcq_Start           level enable from the DAQ switcher
//   ExternalTrigger          asynchronous trigger (synchronised here)
//   CHIPSATB                 chip memory full, active-low, synchronous
//   EndReadout               readout finished
//   AcqTimeout               acquisition window limit, 0 = unlimited
//   SlaveDaq_PWR_ON_*        power-pulsing lines
//   SlaveDaq_RESET_B         chip reset, active-low
//   SlaveDaq_START_ACQ       acquisition window
//   SlaveDaq_StartReadout    one-cycle readout start pulse
//   SlaveDaq_Busy            high outside IDLE
//   TriggerCount             accepted triggers (wraps)
//   AcqCycleCount            completed readouts (wraps)
// All outputs are registered from the current state, so they lag the state
// register by one cycle.
// -----------------------------------------------------------------------------
module slave_daq_ctrl
   import slave_daq_pkg::*;
#(
   parameter int PWR_SETTLE_CYCLES = DEF_PWR_SETTLE_CYCLES,
   parameter int RESET_LOW_CYCLES  = DEF_RESET_LOW_CYCLES,
   parameter int CNT_W             = DEF_CNT_W
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             SlaveAcq_Start,
   input  logic             ExternalTrigger,
   input  logic             CHIPSATB,
   input  logic             EndReadout,
   input  logic [15:0]      AcqTimeout,
   output logic             SlaveDaq_PWR_ON_A,
   output logic             SlaveDaq_PWR_ON_D,
   output logic             SlaveDaq_PWR_ON_ADC,
   output logic             SlaveDaq_PWR_ON_DAC,
   output logic             SlaveDaq_RESET_B,
   output logic             SlaveDaq_START_ACQ,
   output logic             SlaveDaq_StartReadout,
   output logic             SlaveDaq_Busy,
   output logic [CNT_W-1:0] TriggerCount,
   output logic [CNT_W-1:0] AcqCycleCount
);

   localparam logic [31:0]      SETTLE_LAST = 32'(PWR_SETTLE_CYCLES - 1);
   localparam logic [31:0]      RESET_LAST  = 32'(RESET_LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   daqState_t        state_r;
   daqState_t        nextState_s;
   logic [31:0]      timer_r;
   logic             trigRise_s;
   logic             unusedTrigLevel_s;

   logic [3:0]       pwrMask_r;
   logic             resetB_r;
   logic             startAcq_r;
   logic             startReadout_r;
   logic             busy_r;
   logic             inReadoutPrev_r;
   logic [CNT_W-1:0] trigCnt_r;
   logic [CNT_W-1:0] acqCnt_r;

   trig_sync_edge uTrigSync (
      .clk     (Clk),
      .reset   (reset),
      .asyncIn (ExternalTrigger),
      .syncOut (unusedTrigLevel_s),
      .riseOut (trigRise_s)
   );

`ifdef SLAVE_DAQ_TRIG_TIMEOUT_EN
   // ">=" so that lowering AcqTimeout mid-window still terminates it promptly
   logic acqTimeoutHit_s;
   assign acqTimeoutHit_s = (AcqTimeout != 16'd0) &&
                            (timer_r >= ({16'd0, AcqTimeout} - 32'd1));
`else
   logic unusedAcqTimeout_s;
   assign unusedAcqTimeout_s = ^AcqTimeout;
`endif

   // Next-state decode; a dropped enable aborts every state except READOUT
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (SlaveAcq_Start) nextState_s = ST_PWR_UP;
            else                nextState_s = ST_IDLE;
         end
         ST_PWR_UP: begin
            if (!SlaveAcq_Start)             nextState_s = ST_IDLE;
            else if (timer_r == SETTLE_LAST) nextState_s = ST_RESET_CHIP;
            else                             nextState_s = ST_PWR_UP;
         end
         ST_RESET_CHIP: begin
            if (!SlaveAcq_Start)            nextState_s = ST_IDLE;
            else if (timer_r == RESET_LAST) nextState_s = ST_ACQ;
            else                            nextState_s = ST_RESET_CHIP;
         end
         ST_ACQ: begin
            if (!SlaveAcq_Start)               nextState_s = ST_IDLE;
            else if (trigRise_s || !CHIPSATB)  nextState_s = ST_READOUT;
`ifdef SLAVE_DAQ_TRIG_TIMEOUT_EN
            else if (acqTimeoutHit_s)          nextState_s = ST_ABORT;
`endif
            else                               nextState_s = ST_ACQ;
         end
         ST_READOUT: begin
            if (EndReadout) nextState_s = SlaveAcq_Start ? ST_PWR_UP : ST_IDLE;
            else            nextState_s = ST_READOUT;
         end
`ifdef SLAVE_DAQ_TRIG_TIMEOUT_EN
         ST_ABORT: begin
            if (!SlaveAcq_Start) nextState_s = ST_IDLE;
            else                 nextState_s = ST_RESET_CHIP;
         end
`endif
         default: nextState_s = ST_IDLE;
      endcase
   end

   // State register plus shared dwell timer, cleared on every state change
   always_ff @(posedge Clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         timer_r <= 32'd0;
      end else begin
         state_r <= nextState_s;
         if ((nextState_s != state_r) || (state_r == ST_IDLE)) begin
            timer_r <= 32'd0;
         end else begin
            timer_r <= timer_r + 32'd1;
         end
      end
   end

   // Registered chip-control outputs derived from the current state
   always_ff @(posedge Clk) begin
      if (reset) begin
         pwrMask_r       <= PWR_MASK_OFF;
         resetB_r        <= 1'b1;
         startAcq_r      <= 1'b0;
         startReadout_r  <= 1'b0;
         busy_r          <= 1'b0;
         inReadoutPrev_r <= 1'b0;
      end else begin
         pwrMask_r       <= pwrMaskFor(state_r);
         resetB_r        <= (state_r != ST_RESET_CHIP);
         startAcq_r      <= (state_r == ST_ACQ);
         busy_r          <= (state_r != ST_IDLE);
         inReadoutPrev_r <= (state_r == ST_READOUT);
         // Pulse only in the first READOUT cycle
         startReadout_r  <= (state_r == ST_READOUT) && !inReadoutPrev_r;
      end
   end

   // Trigger and readout counters; a trigger counts only when it ends the window
   always_ff @(posedge Clk) begin
      if (reset) begin
         trigCnt_r <= {CNT_W{1'b0}};
         acqCnt_r  <= {CNT_W{1'b0}};
      end else begin
         if ((state_r == ST_ACQ) && (nextState_s == ST_READOUT) && trigRise_s) begin
            trigCnt_r <= trigCnt_r + CNT_ONE;
         end else begin
            trigCnt_r <= trigCnt_r;
         end
         if ((state_r == ST_READOUT) && EndReadout) begin
            acqCnt_r <= acqCnt_r + CNT_ONE;
         end else begin
            acqCnt_r <= acqCnt_r;
         end
      end
   end

   assign SlaveDaq_PWR_ON_A     = pwrMask_r[3];
   assign SlaveDaq_PWR_ON_D     = pwrMask_r[2];
   assign SlaveDaq_PWR_ON_ADC   = pwrMask_r[1];
   assign SlaveDaq_PWR_ON_DAC   = pwrMask_r[0];
   assign SlaveDaq_RESET_B      = resetB_r;
   assign SlaveDaq_START_ACQ    = startAcq_r;
   assign SlaveDaq_StartReadout = startReadout_r;
   assign SlaveDaq_Busy         = busy_r;
   assign TriggerCount          = trigCnt_r;
   assign AcqCycleCount         = acqCnt_r;

endmodule

// File: doc/slave_daq_ctrl.md
# slave_daq_ctrl

Externally triggered acquisition sequencer for the HARDROC front-end chips. It drives the chip power-pulsing lines, RESET_B and START_ACQ, and hands off to the readout logic. It sits directly upstream of the DAQ switcher and feeds its SlaveDaq_* inputs, enabled by the switcher's SlaveAcq_Start. Each cycle runs: power up, settle, chip reset, acquire until an external trigger or chip memory full, read out, repeat.

## Interface
- PWR_SETTLE_CYCLES, 1000: cycles between power-on and chip reset (25 µs at 40 MHz)
- RESET_LOW_CYCLES, 4: width of the RESET_B low pulse
- CNT_W, 16: width of the trigger and cycle counters
- Clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- SlaveAcq_Start  in  1  level enable from the DAQ switcher
- ExternalTrigger  in  1  asynchronous external trigger; synchronised internally
- CHIPSATB  in  1  chip memory full, active-low
- EndReadout  in  1  readout finished, from the readout block
- AcqTimeout  in  16  acquisition window limit in cycles; 0 = unlimited (only with the macro)
- SlaveDaq_PWR_ON_A / _D / _ADC / _DAC  out  1 each  power-pulsing lines
- SlaveDaq_RESET_B  out  1  chip reset, active-low
- SlaveDaq_START_ACQ  out  1  acquisition window
- SlaveDaq_StartReadout  out  1  one-cycle pulse to the readout block
- SlaveDaq_Busy  out  1  high in every state except IDLE
- TriggerCount, AcqCycleCount  out  CNT_W  accepted triggers and completed readouts

## Operation
- States: IDLE, PWR_UP, RESET_CHIP, ACQ, READOUT, and ABORT (ABORT exists only with the macro).
- IDLE: all PWR_ON lines 0, RESET_B 1, START_ACQ 0. If SlaveAcq_Start = 1, go to PWR_UP.
- PWR_UP: all four PWR_ON lines 1. The settle counter runs to PWR_SETTLE_CYCLES-1, then go to RESET_CHIP.
- RESET_CHIP: RESET_B 0 for exactly RESET_LOW_CYCLES cycles, then go to ACQ. Power stays on.
- ACQ: START_ACQ 1.
  - A synchronised trigger rising edge, or CHIPSATB = 0, goes to READOUT.
  - A trigger edge increments TriggerCount, which wraps. CHIPSATB alone does not count.
  - A trigger edge and CHIPSATB low in the same cycle cause one transition and one count.
- READOUT:
  - StartReadout pulses in the first cycle.
  - PWR_ON_A and PWR_ON_ADC go 0; PWR_ON_D and PWR_ON_DAC stay 1.
  - The first cycle with EndReadout = 1 increments AcqCycleCount (wraps). Then go to PWR_UP if SlaveAcq_Start = 1, else to IDLE.
- Triggers outside ACQ are ignored and not counted.
- SlaveAcq_Start falling:
  - In PWR_UP, RESET_CHIP or ACQ: go to IDLE on the next edge.
  - In READOUT: finish the readout first (wait for EndReadout), then go to IDLE.
- EndReadout outside READOUT is ignored.
- Counters are cleared only by reset.

## Timing
- Reset values: all PWR_ON lines 0, RESET_B 1, START_ACQ 0, StartReadout 0, Busy 0, counters 0, state IDLE.
- All outputs are registered.
- SlaveAcq_Start high at edge N: PWR_ON lines and Busy are 1 after edge N+1.
- RESET_B falls PWR_SETTLE_CYCLES cycles after the PWR_ON lines rise. START_ACQ rises on the edge where RESET_B returns to 1.
- Trigger path: 2-FF synchroniser, then a registered edge detector.
  - ExternalTrigger first sampled high at edge N: START_ACQ is 0 and StartReadout is 1 after edge N+3.
  - The minimum trigger pulse width is 2 Clk periods.
- CHIPSATB is already synchronous to Clk. CHIPSATB low at edge N: START_ACQ is 0 after edge N+1.
- EndReadout high at edge N: next state is entered and PWR_ON_A is 1 after edge N+1.

## Configuration
- Macro: SLAVE_DAQ_TRIG_TIMEOUT_EN.
- Defined:
  - A window counter runs in ACQ. When it reaches a nonzero AcqTimeout, go to ABORT: START_ACQ 0, no readout, no counter change.
  - ABORT goes to RESET_CHIP one cycle later, which clears the chip memory before a new window.
  - The window counter clears on every ACQ entry.
- Not defined: AcqTimeout is ignored and ACQ waits indefinitely.

## Structure
- Shared package slave_daq_pkg holds:
  - the state enum
  - default values for PWR_SETTLE_CYCLES, RESET_LOW_CYCLES and CNT_W
  - the power-mask constants per state (A, D, ADC, DAC bit order)
- One sub-module, trig_sync_edge: 2-FF synchroniser plus registered rising-edge detector with synchronous reset. It also serves other external inputs.

## Test plan
- Reset asserted mid-ACQ with START_ACQ = 1 -> next edge: START_ACQ 0, RESET_B 1, all PWR_ON 0, counters 0.
- SlaveAcq_Start 1, PWR_SETTLE_CYCLES = 10 -> RESET_B low 11 cycles after start, for 4 cycles; then START_ACQ 1.
- ExternalTrigger high 2 cycles in ACQ -> START_ACQ 0 and StartReadout 1-cycle pulse 3 edges later, TriggerCount 1. EndReadout -> AcqCycleCount 1, PWR_ON_A back to 1.
- CHIPSATB low together with a trigger edge -> single READOUT entry, TriggerCount +1 only. A trigger during READOUT -> no count.
- SlaveAcq_Start dropped during READOUT -> stays in READOUT until EndReadout, then IDLE with all PWR_ON 0.
- Macro defined, AcqTimeout = 50, no trigger -> START_ACQ falls after 50 cycles, RESET_B pulses, no StartReadout, counters unchanged.
